sdram_rd_cache: RTL and testbench
=================================

SDRAM_RD_CACHE -- requirements
Module: sdram_rd_cache

Interface
REQ-001 SHALL have parameter LINES, default 64, number of direct-mapped one-word lines; power of two, 16..256.
REQ-002 SHALL have port clk  in  1  system clock, same clock as the SDRAM controller.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port cpu_req  in  1  single-cycle strobe; samples cpu_addr, cpu_din, cpu_wrl, cpu_wrh.
REQ-005 SHALL have ports cpu_addr  in  24 (word address [24:1]); cpu_din  in  16; cpu_wrl/cpu_wrh  in  1 each (either high = write).
REQ-006 SHALL have ports cpu_dout  out  16  read data; cpu_rdy  out  1  one-cycle completion pulse; busy  out  1.
REQ-007 SHALL have port flush  in  1  single-cycle strobe that invalidates all lines.
REQ-008 SHALL have ports mem_addr  out  24; mem_din  out  16; mem_wrl/mem_wrh  out  1 each; mem_req  out  1  toggle; mem_ack  in  1  toggle; mem_dout  in  16.

Function
REQ-009 SHALL run a state machine with states IDLE, MISS, WRITE, FLUSH, DRAIN; busy SHALL be high in every state except IDLE.
REQ-010 SHALL split cpu_addr as index = addr[log2(LINES):1] and tag = addr[24:log2(LINES)+1]; each line SHALL hold a valid bit, the tag and 16 data bits.
REQ-011 On a read cpu_req in IDLE that hits a valid line with matching tag, cpu_dout SHALL be the line data and cpu_rdy SHALL pulse on the next cycle; state SHALL stay IDLE.
REQ-012 On a read miss, the block SHALL register mem_addr = cpu_addr, mem_wrl = mem_wrh = 0, toggle mem_req on the next cycle, and enter MISS.
REQ-013 In MISS, when mem_ack equals mem_req, the block SHALL write mem_dout, tag and valid=1 into the line, drive cpu_dout = mem_dout, pulse cpu_rdy in that same cycle, and return to IDLE.
REQ-014 On a write cpu_req, the block SHALL be write-through, no-allocate: it SHALL drive mem_addr, mem_din = cpu_din, mem_wrl/mem_wrh = cpu_wrl/cpu_wrh, toggle mem_req, and enter WRITE.
REQ-015 On a write that hits, the line SHALL be updated at acceptance: only the byte lanes enabled by cpu_wrh (bits 15:8) and cpu_wrl (bits 7:0) are merged. On a write miss, no line SHALL change.
REQ-016 In WRITE, when mem_ack equals mem_req, the block SHALL pulse cpu_rdy and return to IDLE; cpu_dout SHALL be unchanged.
REQ-017 mem_req SHALL toggle exactly once per memory transaction and never while mem_req differs from mem_ack.
REQ-018 cpu_req while busy SHALL be ignored; the master is required to wait for cpu_rdy.
REQ-019 A flush strobe SHALL set a flush-pending flag regardless of state.
REQ-020 In IDLE, a pending flush SHALL take priority over cpu_req; if cpu_req and flush coincide in IDLE, cpu_req SHALL be accepted and the flush executed right after it completes.
REQ-021 FLUSH SHALL clear one valid bit per cycle, index 0 to LINES-1, and then return to IDLE; total duration SHALL be exactly LINES cycles.
REQ-022 Index and tag arithmetic SHALL wrap naturally; address 24'hFFFFFF SHALL map to index LINES-1 with an all-ones tag.

Reset
REQ-023 During reset: cpu_rdy = 0, cpu_dout = 0, mem_wrl = mem_wrh = 0, mem_addr = 0, mem_din = 0, and the flush-pending flag is cleared.
REQ-024 On reset release, if mem_req equals mem_ack, the block SHALL enter FLUSH.
REQ-025 On reset release, if mem_req differs from mem_ack (transaction in flight), the block SHALL enter DRAIN, wait for mem_ack == mem_req, discard mem_dout without pulsing cpu_rdy, then enter FLUSH.
REQ-026 mem_req SHALL NOT be forced during reset, so toggle parity with the controller is preserved.

Configuration
REQ-027 With SDRAM_CACHE_STATS_EN defined, the block SHALL add outputs hit_cnt (16) and miss_cnt (16). They count read hits and read misses, saturate at 16'hFFFF, and clear on reset or flush.
REQ-028 Without SDRAM_CACHE_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-029 After reset and a 64-cycle flush, read 24'h000010 with ack returned after 5 cycles -> one mem_req toggle, cpu_rdy with mem_dout 16'h1234; a repeat read -> cpu_rdy on the next cycle, no toggle.
REQ-030 Hit on 24'h000010 (16'h1234), then write 16'hABCD with cpu_wrh only -> mem write with mem_wrh=1, mem_wrl=0; a later read hits with 16'hAB34.
REQ-031 Read 24'h000010, then read 24'h000050 (same index, different tag, LINES=64) -> miss and refill; read 24'h000010 again -> miss.
REQ-032 flush coincident with a read cpu_req in IDLE -> the read completes first; busy then stays high for 64 cycles; the next read of the same address misses.
REQ-033 Reset asserted during MISS, ack arriving 3 cycles after release -> no cpu_rdy, DRAIN then FLUSH; the next read issues exactly one toggle.
REQ-034 With SDRAM_CACHE_STATS_EN: 3 misses and 5 hits -> miss_cnt=3, hit_cnt=5; after flush -> both 0.

Source files
------------

// File: rtl/sdram_rd_cache.sv
// sdram_rd_cache
//   Direct-mapped, one-word-per-line read cache in front of a toggle-handshake
//   SDRAM controller. Reads that hit are answered from the line store one
//   cycle after the request. Reads that miss fetch one word from memory and
//   refill the line. Writes are write-through and no-allocate: a write that
//   hits merges its enabled byte lanes into the line, and a write that misses
//   leaves the cache unchanged.
//
//   Parameters
//     LINES        number of lines; power of two, 16..256
//
//   Ports
//     clk, reset   system clock; synchronous active-high reset
//     cpu_req      single-cycle request strobe (samples addr/din/wrl/wrh)
//     cpu_addr     word address [24:1]
//     cpu_din      write data
//     cpu_wrl/wrh  byte-lane write enables; either high means a write
//     cpu_dout     read data
//     cpu_rdy      one-cycle completion pulse
//     busy         high while the cache cannot accept cpu_req
//     flush        single-cycle strobe; invalidates every line
//     mem_*        toggle-handshake port to the SDRAM controller; a new
//                  transaction starts when mem_req toggles, and it ends when
//                  mem_ack equals mem_req again
//
//   Optional feature
//     SDRAM_CACHE_STATS_EN  when defined, adds the hit_cnt/miss_cnt read
//                           statistics outputs. They saturate, and they clear
//                           on reset or on a flush strobe.
module sdram_rd_cache #(
  parameter int LINES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [23:0] cpu_addr,
  input  logic [15:0] cpu_din,
  input  logic        cpu_wrl,
  input  logic        cpu_wrh,
  output logic [15:0] cpu_dout,
  output logic        cpu_rdy,
  output logic        busy,
  input  logic        flush,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_din,
  output logic        mem_wrl,
  output logic        mem_wrh,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [15:0] mem_dout
`ifdef SDRAM_CACHE_STATS_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
`endif
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 24 - IW;

  typedef enum logic [2:0] {S_IDLE, S_MISS, S_WRITE, S_FLUSH, S_DRAIN} state_t;

  state_t          state;
  logic [IW-1:0]   flush_idx;
  logic            flush_pend;
  logic            rdy_q;
  logic [15:0]     dout_q;

  logic [LINES-1:0] valid;
  logic [TW-1:0]    tag_mem  [LINES];
  logic [15:0]      data_mem [LINES];

  logic [IW-1:0] cpu_idx, mem_idx, line_idx;
  logic [TW-1:0] cpu_tag, mem_tag, line_tag;
  logic [15:0]   line_data, hit_data;
  logic          is_wr, hit, accept, ack_match, done, fill, line_we;

  assign cpu_idx   = cpu_addr[IW-1:0];
  assign cpu_tag   = cpu_addr[23:IW];
  // mem_addr holds the outstanding transaction's address, so a refill
  // uses it for the line index and tag.
  assign mem_idx   = mem_addr[IW-1:0];
  assign mem_tag   = mem_addr[23:IW];
  assign is_wr     = cpu_wrl | cpu_wrh;
  assign hit_data  = data_mem[cpu_idx];
  assign hit       = valid[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
  assign ack_match = (mem_ack == mem_req);
  // A pending flush blocks new requests, even while the state is still IDLE.
  assign accept    = !reset && (state == S_IDLE) && !flush_pend && cpu_req;
  assign done      = !reset && ((state == S_MISS) || (state == S_WRITE)) && ack_match;
  assign fill      = !reset && (state == S_MISS) && ack_match;

  // Memory completions are reported in the cycle the ack lands. A hit
  // completes through rdy_q/dout_q one cycle after the request.
  assign cpu_rdy  = !reset && (rdy_q || done);
  assign cpu_dout = reset ? 16'h0000 : (fill ? mem_dout : dout_q);
  // Keep busy high across a queued flush, so a master that watches busy
  // never issues a request that would be dropped.
  assign busy     = (state != S_IDLE) || flush_pend;

  // Line store write port. A refill writes the word returned by memory. A
  // write hit merges only the byte lanes that the write enables.
  always_comb begin
    line_we   = 1'b0;
    line_idx  = cpu_idx;
    line_tag  = cpu_tag;
    line_data = mem_dout;
    if (fill) begin
      line_we   = 1'b1;
      line_idx  = mem_idx;
      line_tag  = mem_tag;
      line_data = mem_dout;
    end else if (accept && is_wr && hit) begin
      line_we   = 1'b1;
      line_data = {cpu_wrh ? cpu_din[15:8] : hit_data[15:8],
                   cpu_wrl ? cpu_din[7:0]  : hit_data[7:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_mem[line_idx]  <= line_tag;
      data_mem[line_idx] <= line_data;
    end
  end

  // Control FSM. mem_req is deliberately absent from the reset branch: the
  // controller keeps its own toggle parity across our reset. The valid bits
  // are cleared by the flush sweep that always follows reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ack_match ? S_FLUSH : S_DRAIN;
      flush_idx  <= '0;
      flush_pend <= 1'b0;
      rdy_q      <= 1'b0;
      dout_q     <= 16'h0000;
      mem_addr   <= 24'h000000;
      mem_din    <= 16'h0000;
      mem_wrl    <= 1'b0;
      mem_wrh    <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (flush) flush_pend <= 1'b1;
      case (state)
        S_IDLE: begin
          if (flush_pend) begin
            state     <= S_FLUSH;
            flush_idx <= '0;
            if (!flush) flush_pend <= 1'b0;
          end else if (cpu_req) begin
            if (is_wr) begin
              mem_addr <= cpu_addr;
              mem_din  <= cpu_din;
              mem_wrl  <= cpu_wrl;
              mem_wrh  <= cpu_wrh;
              mem_req  <= ~mem_req;
              state    <= S_WRITE;
            end else if (hit) begin
              dout_q <= hit_data;
              rdy_q  <= 1'b1;
            end else begin
              mem_addr <= cpu_addr;
              mem_wrl  <= 1'b0;
              mem_wrh  <= 1'b0;
              mem_req  <= ~mem_req;
              state    <= S_MISS;
            end
          end
        end
        S_MISS, S_WRITE: begin
          if (ack_match) begin
            if (state == S_MISS) begin
              dout_q         <= mem_dout;
              valid[mem_idx] <= 1'b1;
            end
            // A flush queued during the transaction starts right away, so
            // busy never drops between the completion and the sweep.
            if (flush_pend || flush) begin
              state      <= S_FLUSH;
              flush_idx  <= '0;
              flush_pend <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_FLUSH: begin
          valid[flush_idx] <= 1'b0;
          flush_idx        <= flush_idx + 1'b1;
          if (&flush_idx) state <= S_IDLE;
        end
        S_DRAIN: begin
          // This transaction was orphaned by reset. Its data is discarded
          // and no cpu_rdy is raised for it.
          if (ack_match) begin
            state     <= S_FLUSH;
            flush_idx <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SDRAM_CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      hit_cnt  <= 16'h0000;
      miss_cnt <= 16'h0000;
    end else if (accept && !is_wr) begin
      if (hit) begin
        if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'h0001;
      end else begin
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sdram_rd_cache.sv
// Directed bench for sdram_rd_cache (LINES=64). A small toggle-handshake
// memory model answers each transaction after ack_lat cycles with rdata. It
// also records the address, data and lane enables of the transaction it
// acknowledges. All outputs are sampled on the falling edge.
module tb_sdram_rd_cache;
  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [23:0] cpu_addr;
  logic [15:0] cpu_din;
  logic        cpu_wrl, cpu_wrh;
  logic [15:0] cpu_dout;
  logic        cpu_rdy, busy;
  logic        flush;
  logic [23:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_wrl, mem_wrh, mem_req;
  logic        mem_ack;
  logic [15:0] mem_dout;
`ifdef SDRAM_CACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  sdram_rd_cache #(.LINES(64)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_wrl(cpu_wrl), .cpu_wrh(cpu_wrh),
    .cpu_dout(cpu_dout), .cpu_rdy(cpu_rdy), .busy(busy), .flush(flush),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wrl(mem_wrl),
    .mem_wrh(mem_wrh), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_dout(mem_dout)
`ifdef SDRAM_CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // memory model controls (written by the stimulus process only)
  int          ack_lat  = 5;
  logic        hold_ack = 1'b0;
  logic [15:0] rdata    = 16'h0000;
  // memory model state (written by the model process only)
  int          toggles  = 0;
  logic [23:0] m_addr;
  logic [15:0] m_din;
  logic        m_wrl, m_wrh;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  initial begin : mem_model
    int   cnt;
    logic prev_req;
    cnt = 0;
    mem_dout = 16'h0000;
    #1;
    mem_ack  = mem_req;
    prev_req = mem_req;
    forever begin
      @(posedge clk); #1;
      if (mem_req !== prev_req) begin
        toggles++;
        prev_req = mem_req;
      end
      if (hold_ack || mem_req === mem_ack) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt >= ack_lat) begin
          mem_ack  = mem_req;
          mem_dout = rdata;
          m_addr   = mem_addr;
          m_din    = mem_din;
          m_wrl    = mem_wrl;
          m_wrh    = mem_wrh;
          cnt      = 0;
        end
      end
    end
  end

  // One request. It returns the data seen at cpu_rdy, the latency in cycles
  // (or -1 on timeout) and the number of mem_req toggles.
  task automatic run_req(input logic [23:0] a, input logic [15:0] d,
                         input logic wl, input logic wh, input logic fl,
                         output logic [15:0] dout, output int lat, output int tog);
    int t0;
    bit got;
    t0 = toggles;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_addr = a; cpu_din = d; cpu_wrl = wl; cpu_wrh = wh; flush = fl;
    @(posedge clk); #1;
    cpu_req = 1'b0; flush = 1'b0;
    lat = 0; got = 1'b0; dout = 16'h0000;
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if (cpu_rdy) begin
        got  = 1'b1;
        dout = cpu_dout;
      end
    end
    if (!got) lat = -1;
    tog = toggles - t0;
  endtask

  // Counts the falling edges at which busy is high, stopping at the first
  // edge where it is low.
  task automatic busy_len(output int n);
    bit stop;
    n = 0; stop = 1'b0;
    while (!stop && n < 300) begin
      @(negedge clk);
      if (busy) n++;
      else stop = 1'b1;
    end
  endtask

  initial begin : stim
    logic [15:0] dout;
    int lat, tog, n, rdys, t0;
    reset = 1'b1; cpu_req = 1'b0; cpu_addr = '0; cpu_din = '0;
    cpu_wrl = 1'b0; cpu_wrh = 1'b0; flush = 1'b0;

    // reset values, then the 64-cycle flush that follows release
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy",  cpu_rdy,  0);
    chk("rst_dout", cpu_dout, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_din",  mem_din,  0);
    chk("rst_wr",   {mem_wrh, mem_wrl}, 0);
    chk("rst_busy", busy, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    busy_len(n);
    chk("init_flush_len", n, 64);

    // a miss with the ack 5 cycles after the toggle, then a repeat hit
    ack_lat = 5; rdata = 16'h1234;
    run_req(24'h000010, 16'h0, 1'b0, 1'b0, 1'b0, dout, lat, tog);
    chk("miss_tog",  tog,  1);
    chk("miss_lat",  lat,  5);
    chk("miss_dout", dout, 16'h1234);
    chk("miss_addr", m_addr, 24'h000010);
    chk("miss_wr",   {m_wrh, m_wrl}, 0);
    run_req(24'h000010, 16'h0, 1'b0, 1'b0, 1'b0, dout, lat, tog);
    chk("hit_tog",  tog,  0);
    chk("hit_lat",  lat,  1);
    chk("hit_dout", dout, 16'h1234);

    // high-byte write hit: write-through, and the line merges to AB34
    run_req(24'h000010, 16'hABCD, 1'b0, 1'b1, 1'b0, dout, lat, tog);
    chk("wr_tog",  tog, 1);
    chk("wr_lanes", {m_wrh, m_wrl}, 2'b10);
    chk("wr_din",  m_din, 16'hABCD);
    chk("wr_addr", m_addr, 24'h000010);
    chk("wr_dout_kept", dout, 16'h1234);
    run_req(24'h000010, 16'h0, 1'b0, 1'b0, 1'b0, dout, lat, tog);
    chk("merge_tog",  tog, 0);
    chk("merge_dout", dout, 16'hAB34);

    // a conflicting tag on the same index evicts the line
    rdata = 16'h5555;
    run_req(24'h000050, 16'h0, 1'b0, 1'b0, 1'b0, dout, lat, tog);
    chk("conf_tog",  tog, 1);
    chk("conf_dout", dout, 16'h5555);
    rdata = 16'h1111;
    run_req(24'h000010, 16'h0, 1'b0, 1'b0, 1'b0, dout, lat, tog);
    chk("evict_tog",  tog, 1);
    chk("evict_dout", dout, 16'h1111);

    // a write miss (same index, other tag) must not touch the line
    run_req(24'h000090, 16'h00EE, 1'b1, 1'b0, 1'b0, dout, lat, tog);
    chk("wmiss_tog", tog, 1);
    chk("wmiss_lanes", {m_wrh, m_wrl}, 2'b01);
    run_req(24'h000010, 16'h0, 1'b0, 1'b0, 1'b0, dout, lat, tog);
    chk("wmiss_hit_tog",  tog, 0);
    chk("wmiss_hit_dout", dout, 16'h1111);

    // all-ones address: last index, all-ones tag
    rdata = 16'hBEEF;
    run_req(24'hFFFFFF, 16'h0, 1'b0, 1'b0, 1'b0, dout, lat, tog);
    chk("top_miss_tog", tog, 1);
    run_req(24'hFFFFFF, 16'h0, 1'b0, 1'b0, 1'b0, dout, lat, tog);
    chk("top_hit_tog",  tog, 0);
    chk("top_hit_dout", dout, 16'hBEEF);
    rdata = 16'h0303;
    run_req(24'h00003F, 16'h0, 1'b0, 1'b0, 1'b0, dout, lat, tog);
    chk("top_idx_tagmiss", tog, 1);

    // a flush that coincides with a read: the read goes first, then 64 busy cycles
    rdata = 16'h2020;
    run_req(24'h000020, 16'h0, 1'b0, 1'b0, 1'b1, dout, lat, tog);
    chk("fl_rd_tog",  tog, 1);
    chk("fl_rd_dout", dout, 16'h2020);
    busy_len(n);
    chk("fl_len", n, 64);
    run_req(24'h000020, 16'h0, 1'b0, 1'b0, 1'b0, dout, lat, tog);
    chk("fl_after_miss", tog, 1);
    run_req(24'h000010, 16'h0, 1'b0, 1'b0, 1'b0, dout, lat, tog);
    chk("fl_after_miss2", tog, 1);

    // reset during a miss: drain the late ack with no cpu_rdy, then flush
    hold_ack = 1'b1;
    t0 = toggles;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_addr = 24'h000030; cpu_wrl = 1'b0; cpu_wrh = 1'b0;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    chk("drain_tog", toggles - t0, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    rdys = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("drain_rst_addr", mem_addr, 0);
    chk("drain_rst_rdy",  cpu_rdy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    n = 0;
    repeat (2) begin
      @(negedge clk);
      if (busy) n++;
      if (cpu_rdy) rdys++;
    end
    hold_ack = 1'b0; ack_lat = 1;
    begin
      bit stop;
      stop = 1'b0;
      while (!stop && n < 300) begin
        @(negedge clk);
        if (cpu_rdy) rdys++;
        if (busy) n++;
        else stop = 1'b1;
      end
    end
    chk("drain_busy_len", n, 67);
    chk("drain_no_rdy", rdys, 0);
    ack_lat = 5; rdata = 16'h3030;
    run_req(24'h000030, 16'h0, 1'b0, 1'b0, 1'b0, dout, lat, tog);
    chk("post_drain_tog",  tog, 1);
    chk("post_drain_dout", dout, 16'h3030);

`ifdef SDRAM_CACHE_STATS_EN
    // 3 misses and 5 hits, then a flush clears both counters
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    busy_len(n);
    chk("st_clr_hit",  hit_cnt,  0);
    chk("st_clr_miss", miss_cnt, 0);
    rdata = 16'h4444;
    for (int i = 0; i < 3; i++)
      run_req(24'h000100 + 24'(i), 16'h0, 1'b0, 1'b0, 1'b0, dout, lat, tog);
    for (int i = 0; i < 5; i++)
      run_req(24'h000100 + 24'(i % 3), 16'h0, 1'b0, 1'b0, 1'b0, dout, lat, tog);
    @(negedge clk);
    chk("st_miss", miss_cnt, 3);
    chk("st_hit",  hit_cnt,  5);
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    busy_len(n);
    chk("st_fl_hit",  hit_cnt,  0);
    chk("st_fl_miss", miss_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
